// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_pkg
// Description : Shared opcode constants, NOP encoding and fetch FSM states.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_pkg;

    localparam logic [5:0]  OP_RTYPE = 6'b000000;
    localparam logic [5:0]  OP_ADDI  = 6'b001000;
    localparam logic [5:0]  OP_LW    = 6'b100011;
    localparam logic [5:0]  OP_SW    = 6'b101011;
    localparam logic [5:0]  OP_J     = 6'b000010;
    localparam logic [5:0]  OP_BEQ   = 6'b000100;
    localparam logic [5:0]  OP_BNE   = 6'b000101;

    localparam logic [31:0] INST_NOP = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_HOLD = 2'd2
    } fetch_state_e;

endpackage
`default_nettype wire

// File: rtl/if_id_reg.sv
`default_nettype none
// ============================================================================
// Module      : if_id_reg
// Description : Fetch/decode output register with valid/ready and flush.
// Revision    : 1.0 - initial release
// ============================================================================
module if_id_reg #(
    parameter int unsigned AW = 64,
    parameter int unsigned IW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_load,
    input  logic          i_flush,
    input  logic          i_ready,
    input  logic [IW-1:0] i_inst,
    input  logic [AW-1:0] i_pc,
    output logic          o_valid,
    output logic          o_valid_next,
    output logic [IW-1:0] o_inst,
    output logic [AW-1:0] o_pc,
    output logic [AW-1:0] o_pc_plus4
);

    localparam logic [AW-1:0] c_pc_step = AW'(4);

    logic          valid_q,    valid_d;
    logic [IW-1:0] inst_q,     inst_d;
    logic [AW-1:0] pc_q,       pc_d;
    logic [AW-1:0] pc_plus4_q, pc_plus4_d;

    // A load wins over a flush: the fault NOP is loaded by the redirect itself.
    always_comb begin
        valid_d    = valid_q;
        inst_d     = inst_q;
        pc_d       = pc_q;
        pc_plus4_d = pc_plus4_q;
        if (valid_q && i_ready) begin
            valid_d = 1'b0;
        end
        if (i_flush) begin
            valid_d = 1'b0;
        end
        if (i_load) begin
            valid_d    = 1'b1;
            inst_d     = i_inst;
            pc_d       = i_pc;
            pc_plus4_d = i_pc + c_pc_step;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q    <= 1'b0;
            inst_q     <= '0;
            pc_q       <= '0;
            pc_plus4_q <= '0;
        end else begin
            valid_q    <= valid_d;
            inst_q     <= inst_d;
            pc_q       <= pc_d;
            pc_plus4_q <= pc_plus4_d;
        end
    end

    assign o_valid      = valid_q;
    assign o_valid_next = valid_d;
    assign o_inst       = inst_q;
    assign o_pc         = pc_q;
    assign o_pc_plus4   = pc_plus4_q;

endmodule
`default_nettype wire

// File: rtl/inst_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : inst_fetch_unit
// Description : PC holder and instruction fetcher (req/ack memory side,
//               valid/ready decode side). FETCH_ALIGN_CHECK_EN adds if_fault
//               and turns misaligned redirects into a faulting NOP.
// Revision    : 1.0 - initial release
// ============================================================================
module inst_fetch_unit
    import mips_pkg::*;
#(
    parameter int unsigned     AW       = 64,
    parameter logic [AW-1:0]   RESET_PC = {AW{1'b0}},
    parameter int unsigned     IW       = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    output logic          imem_req,
    output logic [AW-1:0] imem_addr,
    input  logic          imem_ack,
    input  logic [IW-1:0] imem_rdata,
    input  logic          redirect_valid,
    input  logic [AW-1:0] redirect_target,
`ifdef FETCH_ALIGN_CHECK_EN
    output logic          if_fault,
`endif
    output logic          if_valid,
    input  logic          if_ready,
    output logic [IW-1:0] if_inst,
    output logic [5:0]    if_opcode,
    output logic [AW-1:0] if_pc,
    output logic [AW-1:0] if_pc_plus4
);

    localparam logic [AW-1:0] c_pc_step = AW'(4);

    fetch_state_e  state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [AW-1:0] imem_addr_q, imem_addr_d;
    logic          imem_req_q, imem_req_d;
    logic          kill_q, kill_d;

    logic          w_ack, w_busy, w_room, w_take, w_load;
    logic          w_full_next, w_misaligned, w_halt;
    logic [AW-1:0] w_target, w_ld_pc;
    logic [IW-1:0] w_ld_inst;

`ifdef FETCH_ALIGN_CHECK_EN
    logic fault_q, fault_d;

    assign w_misaligned = redirect_valid & (redirect_target[1:0] != 2'b00);
    assign w_target     = redirect_target;
    assign w_halt       = fault_d;

    always_comb begin
        fault_d = fault_q;
        if (redirect_valid) begin
            fault_d = w_misaligned;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fault_q <= 1'b0;
        end else begin
            fault_q <= fault_d;
        end
    end

    assign if_fault = fault_q;
`else
    localparam logic [AW-1:0] c_align_mask = {{(AW-2){1'b1}}, 2'b00};

    assign w_misaligned = 1'b0;
    assign w_target     = redirect_target & c_align_mask;
    assign w_halt       = 1'b0;
`endif

    // An ack that finds the output register full and not draining is dropped
    // and the same PC is re-requested later, so no word is lost or duplicated.
    always_comb begin
        w_ack     = (state_q == ST_REQ) & imem_ack;
        w_busy    = (state_q == ST_REQ) & ~imem_ack;
        w_room    = ~if_valid | if_ready;
        w_take    = w_ack & ~kill_q & ~redirect_valid & w_room;
        w_load    = w_take | w_misaligned;
        w_ld_inst = w_misaligned ? IW'(INST_NOP) : imem_rdata;
        w_ld_pc   = w_misaligned ? w_target : pc_q;
    end

    always_comb begin
        pc_d   = pc_q;
        kill_d = kill_q;
        if (redirect_valid) begin
            pc_d = w_target;
        end else if (w_take) begin
            pc_d = pc_q + c_pc_step;
        end
        if (w_ack) begin
            kill_d = 1'b0;
        end
        if (redirect_valid && w_busy) begin
            kill_d = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: state_d = ST_REQ;
            ST_REQ: begin
                if (w_ack) begin
                    state_d = (!w_full_next || if_ready) ? ST_REQ : ST_HOLD;
                end
            end
            ST_HOLD: state_d = w_full_next ? ST_HOLD : ST_REQ;
            default: state_d = ST_IDLE;
        endcase
        if (w_halt && !w_busy) begin
            state_d = ST_HOLD;
        end
        imem_req_d  = (state_d == ST_REQ);
        imem_addr_d = w_busy ? imem_addr_q : pc_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            pc_q        <= RESET_PC;
            imem_addr_q <= RESET_PC;
            imem_req_q  <= 1'b0;
            kill_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            imem_addr_q <= imem_addr_d;
            imem_req_q  <= imem_req_d;
            kill_q      <= kill_d;
        end
    end

    if_id_reg #(
        .AW (AW),
        .IW (IW)
    ) u_if_id_reg (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_load       (w_load),
        .i_flush      (redirect_valid),
        .i_ready      (if_ready),
        .i_inst       (w_ld_inst),
        .i_pc         (w_ld_pc),
        .o_valid      (if_valid),
        .o_valid_next (w_full_next),
        .o_inst       (if_inst),
        .o_pc         (if_pc),
        .o_pc_plus4   (if_pc_plus4)
    );

    assign imem_req  = imem_req_q;
    assign imem_addr = imem_addr_q;
    assign if_opcode = if_inst[IW-1 -: 6];

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_inst_fetch_unit
// Description : Self-checking bench for inst_fetch_unit; the memory and the
//               expected PC stream are modelled here (FETCH_ALIGN_CHECK_EN
//               enables the fault scenario).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_inst_fetch_unit;

    localparam int AW = 64;
    localparam int IW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_ack;
    logic [IW-1:0] imem_rdata;
    logic          redirect_valid;
    logic [AW-1:0] redirect_target;
    logic          if_valid;
    logic          if_ready;
    logic [IW-1:0] if_inst;
    logic [5:0]    if_opcode;
    logic [AW-1:0] if_pc;
    logic [AW-1:0] if_pc_plus4;
`ifdef FETCH_ALIGN_CHECK_EN
    logic          if_fault;
`endif

    inst_fetch_unit #(
        .AW       (AW),
        .RESET_PC (64'h0),
        .IW       (IW)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ack        (imem_ack),
        .imem_rdata      (imem_rdata),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
`ifdef FETCH_ALIGN_CHECK_EN
        .if_fault        (if_fault),
`endif
        .if_valid        (if_valid),
        .if_ready        (if_ready),
        .if_inst         (if_inst),
        .if_opcode       (if_opcode),
        .if_pc           (if_pc),
        .if_pc_plus4     (if_pc_plus4)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [63:0] exp_pc;
    bit          exp_fault;
    int          n_hs;
    bit          req_prev, ack_prev;
    int          cnt, cur_lat, lat_mode;
    logic [63:0] start_addr, last_new_addr;
    int          n_new;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        logic [31:0] h;
        h = a[31:0] * 32'h9E37_79B1;
        return h ^ a[63:32] ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] req_val);
        n_cmp++;
        assert (obs === req_val) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, req_val);
        end
    endtask

    // One clock: drive inputs at negedge, answer memory, score any handshake.
    task automatic cyc(input bit rst, input bit rdy, input bit redir, input logic [63:0] tgt);
        bit          ack;
        logic [31:0] exp_inst;
        @(negedge clk);
        rst_n           = !rst;
        if_ready        = rdy;
        redirect_valid  = redir && !rst;
        redirect_target = tgt;
        ack = 1'b0;
        if (!rst && imem_req) begin
            if (!req_prev || ack_prev) begin
                cnt           = 0;
                cur_lat       = (lat_mode == 0) ? int'($urandom_range(1, 4)) : lat_mode;
                start_addr    = imem_addr;
                last_new_addr = imem_addr;
                n_new++;
            end else begin
                chk("addr_hold", imem_addr, start_addr);
            end
            ack = (cnt == cur_lat - 1);
            cnt++;
        end
        imem_ack   = ack;
        imem_rdata = ack ? mem_word(imem_addr) : $urandom;
        if (!rst && if_valid && rdy) begin
            exp_inst = exp_fault ? 32'h0 : mem_word(exp_pc);
            chk("hs_pc", if_pc, exp_pc);
            chk("hs_inst", 64'(if_inst), 64'(exp_inst));
            chk("hs_opcode", 64'(if_opcode), 64'(exp_inst[31:26]));
            chk("hs_pc_plus4", if_pc_plus4, exp_pc + 64'd4);
            n_hs++;
            exp_pc = exp_pc + 64'd4;
        end
        if (!rst && redir) begin
`ifdef FETCH_ALIGN_CHECK_EN
            exp_pc    = tgt;
            exp_fault = (tgt[1:0] != 2'b00);
`else
            exp_pc    = tgt & ~64'h3;
            exp_fault = 1'b0;
`endif
        end
        if (rst) begin
            exp_pc    = 64'h0;
            exp_fault = 1'b0;
        end
        req_prev = !rst && imem_req;
        ack_prev = ack;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_req"},   64'(imem_req), 64'h0);
        chk({tag, "_addr"},  imem_addr, 64'h0);
        chk({tag, "_valid"}, 64'(if_valid), 64'h0);
        chk({tag, "_inst"},  64'(if_inst), 64'h0);
        chk({tag, "_pc"},    if_pc, 64'h0);
        chk({tag, "_pc4"},   if_pc_plus4, 64'h0);
`ifdef FETCH_ALIGN_CHECK_EN
        chk({tag, "_fault"}, 64'(if_fault), 64'h0);
`endif
    endtask

    initial begin
        int          h0, n0;
        bit          found;
        logic [63:0] sv_pc;
        logic [31:0] sv_inst;
        rst_n = 1'b0; imem_ack = 1'b0; imem_rdata = '0; redirect_valid = 1'b0;
        redirect_target = '0; if_ready = 1'b0;
        exp_pc = 64'h0; exp_fault = 1'b0; n_hs = 0; req_prev = 1'b0; ack_prev = 1'b0;
        cnt = 0; cur_lat = 1; lat_mode = 1; start_addr = '0; last_new_addr = '0; n_new = 0;

        repeat (3) cyc(1, 0, 0, 64'h0);
        chk_reset("reset");

        // zero-wait memory, decode always ready
        for (int i = 0; i < 4; i++) begin
            cyc(0, 1, 0, 64'h0);
            chk("zw_req", 64'(imem_req), 64'h1);
            chk("zw_addr", imem_addr, 64'(4 * i));
        end
        h0 = n_hs;
        repeat (16) cyc(0, 1, 0, 64'h0);
        chk("zw_throughput", 64'(n_hs - h0), 64'd16);

        // three-cycle memory latency
        lat_mode = 3;
        h0 = n_hs;
        repeat (30) cyc(0, 1, 0, 64'h0);
        chk("lat3_rate", 64'((n_hs - h0) >= 9 && (n_hs - h0) <= 11), 64'h1);

        // decode stalls for four cycles
        lat_mode = 1;
        repeat (5) cyc(0, 1, 0, 64'h0);
        chk("stall_pre_valid", 64'(if_valid), 64'h1);
        sv_pc   = if_pc;
        sv_inst = if_inst;
        for (int i = 0; i < 4; i++) begin
            cyc(0, 0, 0, 64'h0);
            chk("stall_req", 64'(imem_req), 64'h0);
            chk("stall_valid", 64'(if_valid), 64'h1);
            chk("stall_pc", if_pc, sv_pc);
            chk("stall_inst", 64'(if_inst), 64'(sv_inst));
        end
        h0 = n_hs;
        repeat (4) cyc(0, 1, 0, 64'h0);
        chk("stall_resume", 64'(n_hs > h0), 64'h1);

        // redirect while the request at 0x8 is outstanding
        repeat (2) cyc(1, 0, 0, 64'h0);
        lat_mode = 3;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (imem_req && imem_addr == 64'h8 && (!req_prev || ack_prev)) found = 1'b1;
            else cyc(0, 1, 0, 64'h0);
        end
        chk("pend_found", 64'(found), 64'h1);
        cyc(0, 1, 1, 64'h100);
        n0 = n_new;
        for (int i = 0; i < 12 && n_new == n0; i++) cyc(0, 1, 0, 64'h0);
        chk("pend_next_addr", last_new_addr, 64'h100);
        h0 = n_hs;
        repeat (8) cyc(0, 1, 0, 64'h0);
        chk("pend_progress", 64'(n_hs > h0), 64'h1);

        // redirect in the same cycle as the ack for 0xC
        repeat (2) cyc(1, 0, 0, 64'h0);
        lat_mode = 1;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (imem_req && imem_addr == 64'hC) found = 1'b1;
            else cyc(0, 1, 0, 64'h0);
        end
        chk("ackredir_found", 64'(found), 64'h1);
        cyc(0, 1, 1, 64'h40);
        chk("ackredir_flush", 64'(if_valid), 64'h0);
        chk("ackredir_addr", imem_addr, 64'h40);
        cyc(0, 1, 0, 64'h0);
        chk("ackredir_pc", if_pc, 64'h40);
        repeat (4) cyc(0, 1, 0, 64'h0);

        // reset in the middle of an outstanding request
        lat_mode = 3;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            if (imem_req && (!req_prev || ack_prev)) found = 1'b1;
            else cyc(0, 1, 0, 64'h0);
        end
        chk("midrst_found", 64'(found), 64'h1);
        cyc(0, 1, 0, 64'h0);
        cyc(1, 1, 0, 64'h0);
        chk_reset("midrst");
        cyc(0, 1, 0, 64'h0);
        chk("midrst_req", 64'(imem_req), 64'h1);
        chk("midrst_addr", imem_addr, 64'h0);
        h0 = n_hs;
        repeat (10) cyc(0, 1, 0, 64'h0);
        chk("midrst_progress", 64'(n_hs > h0), 64'h1);

        // random latency, back-pressure and redirects (including PC wrap)
        lat_mode = 0;
        h0 = n_hs;
        for (int i = 0; i < 400; i++) begin
            int          r;
            logic [63:0] tgt;
            r   = int'($urandom_range(0, 99));
            tgt = (r == 0) ? 64'hFFFF_FFFF_FFFF_FFF0 : {48'h0, 16'($urandom) & 16'hFFFC};
            cyc(0, $urandom_range(0, 9) < 7, r < 4, tgt);
        end
        chk("rand_progress", 64'((n_hs - h0) >= 30), 64'h1);

`ifdef FETCH_ALIGN_CHECK_EN
        // misaligned redirect faults and halts fetching
        lat_mode = 1;
        repeat (3) cyc(0, 1, 0, 64'h0);
        cyc(0, 1, 1, 64'h102);
        chk("fault_flag", 64'(if_fault), 64'h1);
        chk("fault_valid", 64'(if_valid), 64'h1);
        chk("fault_inst", 64'(if_inst), 64'h0);
        chk("fault_pc", if_pc, 64'h102);
        chk("fault_req", 64'(imem_req), 64'h0);
        cyc(0, 1, 0, 64'h0);
        for (int i = 0; i < 4; i++) begin
            cyc(0, 1, 0, 64'h0);
            chk("fault_halt_req", 64'(imem_req), 64'h0);
            chk("fault_halt_valid", 64'(if_valid), 64'h0);
            chk("fault_hold", 64'(if_fault), 64'h1);
        end
        cyc(0, 1, 1, 64'h200);
        chk("fault_clear", 64'(if_fault), 64'h0);
        n0 = n_new;
        for (int i = 0; i < 6 && n_new == n0; i++) cyc(0, 1, 0, 64'h0);
        chk("fault_next_addr", last_new_addr, 64'h200);
        h0 = n_hs;
        repeat (6) cyc(0, 1, 0, 64'h0);
        chk("fault_progress", 64'(n_hs > h0), 64'h1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
